// File: rtl/agro_ctrl.sv
// agro_ctrl: synchronises/debounces the agro button and sequences estado/sinal/concluido
// for the digit block (IDLE -> ARM -> ATIVO run/drop -> COOLDOWN).
module agro_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int ACTIVE_CYCLES   = 16,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_raw,
    input  logic       abortar,
    output logic       botaoAgro,
    output logic [1:0] estado,
    output logic       sinal,
    output logic       concluido
);
    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] ACT_LAST  = 8'(ACTIVE_CYCLES - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_CYCLES - 1);

    // DROP shares estado=11 with ATIVO; bit 2 only separates the single sinal=0 cycle
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ARM   = 3'b001,
        ATIVO = 3'b011,
        DROP  = 3'b111,
        COOL  = 3'b010
    } state_t;

    logic       r_sync1, r_sync2, r_botao;
    logic [7:0] r_db_cnt;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_sinal, r_conc;
    state_t     w_next_state;
    logic [7:0] w_last, w_next_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_botao  <= 1'b0;
            r_db_cnt <= 8'd0;
        end else begin
            r_sync1 <= botao_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_botao) begin
                r_db_cnt <= 8'd0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= 8'd0;
                r_botao  <= ~r_botao;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = r_botao ? ARM : IDLE;
            ARM:     w_next_state = (abortar || !r_botao) ? IDLE : (r_cnt == HOLD_LAST) ? ATIVO : ARM;
            ATIVO:   w_next_state = (abortar || r_cnt == ACT_LAST) ? DROP : ATIVO;
            DROP:    w_next_state = COOL;
            COOL:    w_next_state = (r_cnt == COOL_LAST && !r_botao) ? IDLE : COOL;
            default: w_next_state = IDLE;
        endcase
    end

    // Counter clears on every state change and saturates at the current state's terminal value
    assign w_last = (r_state == ARM)   ? HOLD_LAST :
                    (r_state == ATIVO) ? ACT_LAST  :
                    (r_state == COOL)  ? COOL_LAST : 8'd0;
    assign w_next_cnt = (w_next_state != r_state) ? 8'd0 :
                        (r_cnt == w_last)         ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_sinal <= 1'b0;
            r_conc  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_sinal <= (w_next_state == ATIVO);
            r_conc  <= (w_next_state == DROP);
        end
    end

    assign botaoAgro = r_botao;
    assign estado    = r_state[1:0];
    assign sinal     = r_sinal;
    assign concluido = r_conc;
endmodule

// File: tb/tb_agro_ctrl.sv
// tb_agro_ctrl: directed scenarios for agro_ctrl with hand-derived per-cycle expectations
// (cycle k = k-th rising edge after botao_raw is driven; sampled 1 ns after the edge).
module tb_agro_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       botao_raw = 1'b0;
    logic       abortar = 1'b0;
    logic       botaoAgro;
    logic [1:0] estado;
    logic       sinal;
    logic       concluido;
    int         n_tests = 0;
    int         n_fail = 0;

    agro_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .botao_raw(botao_raw),
        .abortar  (abortar),
        .botaoAgro(botaoAgro),
        .estado   (estado),
        .sinal    (sinal),
        .concluido(concluido)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] obs();
        return {botaoAgro, estado, sinal, concluido};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [4:0] e;
        n_tests++;
        if (obs() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), 5'b0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clock);
            #1;
            e = 5'b0;
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL idle k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] e;
        @(posedge clock);
        #1 botao_raw = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clock);
            #1;
            e = 5'b0;
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, obs(), e);
            end
            if (k == 3) botao_raw = 1'b0;
        end
    endtask

    task automatic test_full_cycle(input string tag);
        logic [4:0] e;
        @(posedge clock);
        #1 botao_raw = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            e[4]   = (k >= 6 && k <= 45);
            e[3:2] = (k <= 6) ? 2'b00 : (k <= 14) ? 2'b01 : (k <= 31) ? 2'b11 : (k <= 46) ? 2'b10 : 2'b00;
            e[1]   = (k >= 15 && k <= 30);
            e[0]   = (k == 31);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL %s k=%0d got=%b exp=%b", tag, k, obs(), e);
            end
            if (k == 40) botao_raw = 1'b0;
        end
    endtask

    task automatic test_arm_cancel();
        logic [4:0] e;
        @(posedge clock);
        #1 botao_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            e[4]   = (k >= 6 && k <= 10);
            e[3:2] = (k >= 7 && k <= 11) ? 2'b01 : 2'b00;
            e[1:0] = 2'b00;
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL arm_cancel k=%0d got=%b exp=%b", k, obs(), e);
            end
            if (k == 5) botao_raw = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [4:0] e;
        @(posedge clock);
        #1 botao_raw = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clock);
            #1;
            e[4]   = (k >= 6 && k <= 21);
            e[3:2] = (k <= 6) ? 2'b00 : (k <= 14) ? 2'b01 : (k <= 22) ? 2'b11 : (k <= 30) ? 2'b10 : 2'b00;
            e[1]   = (k >= 15 && k <= 21);
            e[0]   = (k == 22);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL abort k=%0d got=%b exp=%b", k, obs(), e);
            end
            if (k == 16) botao_raw = 1'b0;
            abortar = (k == 21);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] e;
        @(posedge clock);
        #1 botao_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            e[4]   = 1'b1;
            e[3:2] = (k <= 6) ? 2'b00 : (k <= 14) ? 2'b01 : 2'b11;
            e[1]   = (k >= 15);
            e[0]   = 1'b0;
            e[4]   = (k >= 6);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", obs(), 5'b0);
        end
        botao_raw = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if (obs() !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_held k=%0d got=%b exp=%b", k, obs(), 5'b0);
            end
        end
        reset = 1'b0;
        idle_cycles(10);
        test_full_cycle("after_reset");
    endtask

    initial begin
        test_reset();
        test_glitch();
        idle_cycles(5);
        test_full_cycle("full_cycle");
        idle_cycles(5);
        test_arm_cancel();
        idle_cycles(5);
        test_abort();
        idle_cycles(5);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
